axi_lite_master: RTL and testbench

Single-outstanding AXI4-Lite master that converts a simple strobe-based command interface into AXI-Lite read and write transactions and returns one response per command. It is the initiator counterpart to the team's `axi_lite_slave` register bridge. It is used by control sequencers and test harnesses to drive any AXI-Lite register block in the design.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_master_watchdog.sv | 36 +++
 rtl/axi_lite_master.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the bridge FSM encoding.
// Imported by the master (and reusable by the slave bridge).
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } axi_lite_state_t;

endpackage

// File: rtl/axi_lite_master_watchdog.sv
// Load/clear/expire cycle counter for the AXI-Lite master abort path.
// Only instantiated when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module axi_lite_master_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;
  logic          run;

  // The load cycle counts as cycle 0, so the first counted cycle reads 1.
  assign expire = run && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= CW'(1);
      run <= 1'b1;
    end else if (clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (run && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: strobe command in, one response out.
// Optional watchdog abort via `define AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_cmd_stb,
  output logic                    o_cmd_rdy,
  input  logic                    i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_data,
  input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
  output logic                    o_rsp_stb,
  output logic [1:0]              o_rsp_resp,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic                    o_rsp_timeout,
  output logic                    o_awvalid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  input  logic                    i_awready,
  output logic                    o_wvalid,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_wready,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_arready,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [1:0]              i_rresp,
  input  logic [DATA_WIDTH-1:0]   i_rdata
);

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || TIMEOUT_CYCLES < 2)
  begin : g_bad_cfg
    $error("axi_lite_master: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  axi_lite_state_t state_q, state_d;

  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [STROBE_WIDTH-1:0] strb_q;

  logic                    accept;
  logic                    cap;
  logic [1:0]              cap_resp;
  logic [DATA_WIDTH-1:0]   cap_data;

  assign accept   = (state_q == ST_IDLE) && i_cmd_stb;
  assign o_awaddr = addr_q;
  assign o_araddr = addr_q;
  assign o_wdata  = data_q;
  assign o_wstrb  = strb_q;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic expire;
  logic cap_to;
  logic busy;

  assign busy = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

  axi_lite_master_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (i_axi_clk),
    .rst_n  (i_axi_rst),
    .load   (accept),
    .clear  (state_d == ST_DONE),
    .expire (expire)
  );
`endif

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cap       = 1'b0;
    cap_resp  = RESP_OKAY;
    cap_data  = '0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    cap_to    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_stb) begin
          state_d   = i_cmd_wr ? ST_WR_REQ : ST_RD_REQ;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_WR_REQ: begin
        aw_done_d = aw_done_q | (o_awvalid & i_awready);
        w_done_d  = w_done_q | (o_wvalid & i_wready);
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (o_bready && i_bvalid) begin
          state_d  = ST_DONE;
          cap      = 1'b1;
          cap_resp = i_bresp;
        end
      end
      ST_RD_REQ: begin
        if (o_arvalid && i_arready) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (o_rready && i_rvalid) begin
          state_d  = ST_DONE;
          cap      = 1'b1;
          cap_resp = i_rresp;
          cap_data = i_rdata;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    // A genuine completion in the expiry cycle still wins over the abort.
    if (expire && busy && state_d != ST_DONE) begin
      state_d  = ST_DONE;
      cap      = 1'b1;
      cap_resp = RESP_SLVERR;
      cap_data = '0;
      cap_to   = 1'b1;
    end
`endif
  end

  // Outputs are decoded from the next state so every AXI signal is a flop.
  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      state_q    <= ST_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      o_cmd_rdy  <= 1'b1;
      o_awvalid  <= 1'b0;
      o_wvalid   <= 1'b0;
      o_bready   <= 1'b0;
      o_arvalid  <= 1'b0;
      o_rready   <= 1'b0;
      o_rsp_stb  <= 1'b0;
      o_rsp_resp <= RESP_OKAY;
      o_rsp_data <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      o_cmd_rdy <= (state_d == ST_IDLE);
      o_awvalid <= (state_d == ST_WR_REQ) && !aw_done_d;
      o_wvalid  <= (state_d == ST_WR_REQ) && !w_done_d;
      o_bready  <= (state_d == ST_WR_RESP);
      o_arvalid <= (state_d == ST_RD_REQ);
      o_rready  <= (state_d == ST_RD_RESP);
      o_rsp_stb <= (state_d == ST_DONE);
      if (accept) begin
        addr_q <= i_cmd_addr;
        data_q <= i_cmd_data;
        strb_q <= i_cmd_strb;
      end
      if (cap) begin
        o_rsp_resp <= cap_resp;
        o_rsp_data <= cap_data;
      end
    end
  end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      o_rsp_timeout <= 1'b0;
    end else if (cap) begin
      o_rsp_timeout <= cap_to;
    end
  end
`else
  assign o_rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: vector table plus reset/timeout runs.
// Timeout run is included when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master;

  logic        clk;
  logic        rst;
  logic        i_cmd_stb;
  logic        o_cmd_rdy;
  logic        i_cmd_wr;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic [3:0]  i_cmd_strb;
  logic        o_rsp_stb;
  logic [1:0]  o_rsp_resp;
  logic [31:0] o_rsp_data;
  logic        o_rsp_timeout;
  logic        o_awvalid;
  logic [31:0] o_awaddr;
  logic        i_awready;
  logic        o_wvalid;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        i_wready;
  logic        i_bvalid;
  logic        o_bready;
  logic [1:0]  i_bresp;
  logic        o_arvalid;
  logic [31:0] o_araddr;
  logic        i_arready;
  logic        i_rvalid;
  logic        o_rready;
  logic [1:0]  i_rresp;
  logic [31:0] i_rdata;

  axi_lite_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .STROBE_WIDTH   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_axi_clk     (clk),
    .i_axi_rst     (rst),
    .i_cmd_stb     (i_cmd_stb),
    .o_cmd_rdy     (o_cmd_rdy),
    .i_cmd_wr      (i_cmd_wr),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_data    (i_cmd_data),
    .i_cmd_strb    (i_cmd_strb),
    .o_rsp_stb     (o_rsp_stb),
    .o_rsp_resp    (o_rsp_resp),
    .o_rsp_data    (o_rsp_data),
    .o_rsp_timeout (o_rsp_timeout),
    .o_awvalid     (o_awvalid),
    .o_awaddr      (o_awaddr),
    .i_awready     (i_awready),
    .o_wvalid      (o_wvalid),
    .o_wdata       (o_wdata),
    .o_wstrb       (o_wstrb),
    .i_wready      (i_wready),
    .i_bvalid      (i_bvalid),
    .o_bready      (o_bready),
    .i_bresp       (i_bresp),
    .o_arvalid     (o_arvalid),
    .o_araddr      (o_araddr),
    .i_arready     (i_arready),
    .i_rvalid      (i_rvalid),
    .o_rready      (o_rready),
    .i_rresp       (i_rresp),
    .i_rdata       (i_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a_cyc: cycle AW/AR ready rises; w_cyc: W ready; r_cyc: B/R valid rises.
  // exp_cyc: cycle of o_rsp_stb counted from acceptance (cycle 0).
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          a_cyc;
    int          w_cyc;
    int          r_cyc;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_cyc;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp,
               $time);
    end
  endtask

  task automatic slave_idle();
    i_awready = 1'b0;
    i_wready  = 1'b0;
    i_bvalid  = 1'b0;
    i_bresp   = 2'b00;
    i_arready = 1'b0;
    i_rvalid  = 1'b0;
    i_rresp   = 2'b00;
    i_rdata   = 32'h0;
  endtask

  // Entered at the negedge of the accept cycle; leaves at the negedge of
  // the cycle after o_rsp_stb so the next command goes back-to-back.
  task automatic run_vec(input vec_t v, input bit noise);
    bit got = 1'b0;
    bit dn  = 1'b0;
    int s   = -1;
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    chk("cmd_rdy_idle", o_cmd_rdy, 1);
    slave_idle();
    i_cmd_stb  = 1'b1;
    i_cmd_wr   = v.wr;
    i_cmd_addr = v.addr;
    i_cmd_data = v.data;
    i_cmd_strb = v.strb;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (noise) begin
        i_cmd_stb  = 1'b1;
        i_cmd_wr   = ~v.wr;
        i_cmd_addr = 32'hBAD0_0BAD;
        i_cmd_data = 32'h5555_AAAA;
        i_cmd_strb = 4'h6;
      end else begin
        i_cmd_stb = 1'b0;
      end
      got = o_rsp_stb;
      if (!got) chk("cmd_rdy_busy", o_cmd_rdy, 0);
      chk("awvalid", o_awvalid, v.wr && c <= v.a_cyc);
      chk("wvalid", o_wvalid, v.wr && c <= v.w_cyc);
      chk("arvalid", o_arvalid, !v.wr && c <= v.a_cyc);
      if (o_awvalid) chk("awaddr", o_awaddr, v.addr);
      if (o_wvalid) begin
        chk("wdata", o_wdata, v.data);
        chk("wstrb", o_wstrb, v.strb);
      end
      if (o_arvalid) chk("araddr", o_araddr, v.addr);
      if (v.wr) begin
        i_awready = c >= v.a_cyc;
        i_wready  = c >= v.w_cyc;
        i_bvalid  = c >= v.r_cyc && !dn;
        i_bresp   = v.resp;
        if (o_awvalid && i_awready) aw_n++;
        if (o_wvalid && i_wready) w_n++;
        if (i_bvalid && o_bready) begin
          b_n++;
          dn = 1'b1;
        end
      end else begin
        i_arready = c >= v.a_cyc;
        i_rvalid  = c >= v.r_cyc && !dn;
        i_rresp   = v.resp;
        i_rdata   = v.rdata;
        if (o_arvalid && i_arready) ar_n++;
        if (i_rvalid && o_rready) begin
          r_n++;
          dn = 1'b1;
        end
      end
      if (got) begin
        s = c;
        chk("rsp_resp", o_rsp_resp, v.exp_resp);
        chk("rsp_data", o_rsp_data, v.exp_data);
        chk("rsp_timeout", o_rsp_timeout, 0);
        break;
      end
    end
    chk("rsp_cycle", s, v.exp_cyc);
    if (v.wr) begin
      chk("aw_handshakes", aw_n, 1);
      chk("w_handshakes", w_n, 1);
      chk("b_handshakes", b_n, 1);
    end else begin
      chk("ar_handshakes", ar_n, 1);
      chk("r_handshakes", r_n, 1);
    end
    @(negedge clk);
    chk("rsp_stb_one_cycle", o_rsp_stb, 0);
    chk("cmd_rdy_after", o_cmd_rdy, 1);
    chk("rsp_resp_hold", o_rsp_resp, v.exp_resp);
    chk("rsp_data_hold", o_rsp_data, v.exp_data);
    slave_idle();
    i_cmd_stb = 1'b0;
  endtask

  initial begin
    int s;
    checks = 0;
    errors = 0;
    vecs[0] = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 1, 1, 2,
                2'b00, 32'h0, 3, 2'b00, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3, 5, 1, 6,
                2'b00, 32'h0, 7, 2'b00, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 4'hC, 2, 3, 4,
                2'b11, 32'h0, 5, 2'b11, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0024, 32'h0BAD_F00D, 4'h1, 1, 4, 2,
                2'b10, 32'h0, 6, 2'b10, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 1, 0, 5,
                2'b00, 32'h1000_0000, 6, 2'b00, 32'h1000_0000};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 0, 2,
                2'b10, 32'hFFFF_FFFF, 3, 2'b10, 32'hFFFF_FFFF};
    vecs[6] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 3, 0, 3,
                2'b01, 32'hCAFE_F00D, 5, 2'b01, 32'hCAFE_F00D};
    vecs[7] = '{1'b0, 32'h0000_000C, 32'h0, 4'h0, 2, 0, 7,
                2'b00, 32'h0000_0001, 8, 2'b00, 32'h0000_0001};

    rst        = 1'b0;
    i_cmd_stb  = 1'b0;
    i_cmd_wr   = 1'b0;
    i_cmd_addr = 32'h0;
    i_cmd_data = 32'h0;
    i_cmd_strb = 4'h0;
    slave_idle();
    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", o_cmd_rdy, 1);
    chk("rst_valids", {o_awvalid, o_wvalid, o_arvalid}, 0);
    chk("rst_readies", {o_bready, o_rready}, 0);
    chk("rst_rsp_stb", o_rsp_stb, 0);
    chk("rst_rsp_resp", o_rsp_resp, 0);
    chk("rst_rsp_data", o_rsp_data, 0);
    chk("rst_rsp_timeout", o_rsp_timeout, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i[0]);

    // Reset while AR is pending: abandon with no response.
    i_cmd_stb  = 1'b1;
    i_cmd_wr   = 1'b0;
    i_cmd_addr = 32'h0000_0040;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    chk("midrst_arvalid_1", o_arvalid, 1);
    @(negedge clk);
    chk("midrst_arvalid_2", o_arvalid, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_valids", {o_awvalid, o_wvalid, o_arvalid}, 0);
    chk("midrst_readies", {o_bready, o_rready}, 0);
    chk("midrst_cmd_rdy", o_cmd_rdy, 1);
    chk("midrst_rsp_stb", o_rsp_stb, 0);
    chk("midrst_rsp_data", o_rsp_data, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_rsp", o_rsp_stb, 0);
    end
    run_vec(vecs[4], 1'b0);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    // Slave accepts AW/W but never answers B: watchdog must abort.
    s = -1;
    chk("to_cmd_rdy", o_cmd_rdy, 1);
    i_cmd_stb  = 1'b1;
    i_cmd_wr   = 1'b1;
    i_cmd_addr = 32'h0000_0080;
    i_cmd_data = 32'h0000_00FF;
    i_cmd_strb = 4'hF;
    i_awready  = 1'b1;
    i_wready   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      i_cmd_stb = 1'b0;
      if (o_rsp_stb) begin
        s = c;
        break;
      end
    end
    chk("to_cycle", s, 16);
    chk("to_rsp_resp", o_rsp_resp, 2'b10);
    chk("to_rsp_timeout", o_rsp_timeout, 1);
    chk("to_rsp_data", o_rsp_data, 0);
    @(negedge clk);
    chk("to_bready_after", o_bready, 0);
    chk("to_valids_after", {o_awvalid, o_wvalid}, 0);
    chk("to_cmd_rdy_after", o_cmd_rdy, 1);
    slave_idle();
`else
    s = 0;
    chk("no_timeout_flag", o_rsp_timeout + s, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
